lisnoc_output_fifo_buffer: RTL and testbench

//  Output-port flit buffer of the LISNoC router, directly downstream of the switch arbiter.

---
 rtl/lisnoc_pkg.sv | 25 ++
 rtl/lisnoc_pkt_checker.sv | 50 +++++
 rtl/lisnoc_output_fifo_buffer.sv | 109 ++++++++++
 tb/tb_lisnoc_output_fifo_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lisnoc_pkg.sv
// Shared types for the LISNoC output buffer: flit type codes, packet FSM states, default widths.
package lisnoc_pkg;

  localparam int unsigned FLIT_DATA_WIDTH = 32;
  localparam int unsigned FLIT_TYPE_WIDTH = 2;
  localparam int unsigned FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEADER  = 2'b01,
    FLIT_TAIL    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } pkt_state_e;

  // A flit that closes a packet: TAIL of a multi-flit packet or a SINGLE.
  function automatic logic is_pkt_end(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_pkt_checker.sv
// Packet framing tracker: follows HEADER..TAIL / SINGLE sequencing on accepted flits and
// raises a sticky proto_err on any out-of-order flit type.
module lisnoc_pkt_checker
  import lisnoc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  flit_type_e flit_type,
  output logic       proto_err
);

  pkt_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      proto_err <= 1'b0;
    end else if (push) begin
      case (state)
        ST_IDLE: begin
          case (flit_type)
            FLIT_HEADER: state <= ST_PKT;
            FLIT_SINGLE: state <= ST_IDLE;
            default: begin
              state     <= ST_IDLE;
              proto_err <= 1'b1;
            end
          endcase
        end
        ST_PKT: begin
          case (flit_type)
            FLIT_PAYLOAD: state <= ST_PKT;
            FLIT_TAIL:    state <= ST_IDLE;
            FLIT_HEADER: begin
              state     <= ST_PKT;
              proto_err <= 1'b1;
            end
            default: begin
              state     <= ST_IDLE;
              proto_err <= 1'b1;
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lisnoc_output_fifo_buffer.sv
// LISNoC router output-port flit FIFO with packet counting and framing check.
// Optional LISNOC_OUTFIFO_BYPASS_EN: empty-queue flits pass straight through to the link.
module lisnoc_output_fifo_buffer
  import lisnoc_pkg::*;
#(
  parameter int unsigned flit_data_width = FLIT_DATA_WIDTH,
  parameter int unsigned flit_type_width = FLIT_TYPE_WIDTH,
  parameter int unsigned depth           = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [flit_data_width+flit_type_width-1:0] in_flit,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [flit_data_width+flit_type_width-1:0] out_flit,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [$clog2(depth+1)-1:0]                 packet_cnt,
  output logic                                       proto_err
);

  localparam int unsigned flit_width = flit_data_width + flit_type_width;
  localparam int unsigned idx_width  = $clog2(depth);
  localparam int unsigned ptr_width  = idx_width + 1;
  localparam int unsigned cnt_width  = $clog2(depth + 1);

  logic [flit_width-1:0] mem [depth];
  logic [ptr_width-1:0]  wr_ptr;
  logic [ptr_width-1:0]  rd_ptr;
  logic [idx_width-1:0]  wr_idx;
  logic [idx_width-1:0]  rd_idx;
  logic                  empty;
  logic                  full;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic                  wr_end;
  logic                  rd_end;
  flit_type_e            in_type;
  flit_type_e            head_type;
  logic [flit_width-1:0] head_flit;

  assign wr_idx    = wr_ptr[idx_width-1:0];
  assign rd_idx    = rd_ptr[idx_width-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[ptr_width-1] != rd_ptr[ptr_width-1]);
  assign head_flit = mem[rd_idx];

  // Type codes live in the two lowest bits of the type field, directly above the payload.
  assign in_type   = flit_type_e'(in_flit[flit_data_width +: 2]);
  assign head_type = flit_type_e'(head_flit[flit_data_width +: 2]);

  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign rd_en    = !rst && !empty && out_ready;

`ifdef LISNOC_OUTFIFO_BYPASS_EN
  logic bypass;
  // An empty queue forwards the arriving flit; it is stored only if the link stalls.
  assign bypass    = accept && empty && out_ready;
  assign wr_en     = accept && !bypass;
  assign out_valid = !rst && (!empty || in_valid);
  assign out_flit  = empty ? in_flit : head_flit;
`else
  assign wr_en     = accept;
  assign out_valid = !rst && !empty;
  assign out_flit  = head_flit;
`endif

  assign wr_end = wr_en && is_pkt_end(in_type);
  assign rd_end = rd_en && is_pkt_end(head_type);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= in_flit;
    end
  end

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      packet_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ptr_width'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ptr_width'(1);
      end
      case ({wr_end, rd_end})
        2'b10:   packet_cnt <= packet_cnt + cnt_width'(1);
        2'b01:   packet_cnt <= packet_cnt - cnt_width'(1);
        default: packet_cnt <= packet_cnt;
      endcase
    end
  end

  // Framing follows every accepted flit, including ones that bypass storage.
  lisnoc_pkt_checker u_pkt_checker (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .flit_type (in_type),
    .proto_err (proto_err)
  );

endmodule

// File: tb/tb_lisnoc_output_fifo_buffer.sv
// Directed bench for lisnoc_output_fifo_buffer (depth 4, 32-bit payload, 2-bit type).
module tb_lisnoc_output_fifo_buffer;

  localparam logic [1:0] T_P = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_T = 2'b10;
  localparam logic [1:0] T_S = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  packet_cnt;
  logic        proto_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lisnoc_output_fifo_buffer #(
    .flit_data_width (32),
    .flit_type_width (2),
    .depth           (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .packet_cnt (packet_cnt),
    .proto_err  (proto_err)
  );

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] seq3 [4];
    seq3 = '{T_H, T_P, T_P, T_T};

    rst       = 1'b1;
    in_flit   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    chk("post_rst_packet_cnt", 64'(packet_cnt), 64'(0));
    chk("post_rst_proto_err", 64'(proto_err), 64'(0));
    tick();

    // 1: fill to full with the link stalled, then drain in order
    for (int i = 0; i < 5; i++) begin
      in_flit  = mk(T_S, 32'h100 + 32'(i));
      in_valid = 1'b1;
      #1;
      chk("t1_in_ready", 64'(in_ready), (i < 4) ? 64'(1) : 64'(0));
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t1_full_in_ready", 64'(in_ready), 64'(0));
    chk("t1_full_out_valid", 64'(out_valid), 64'(1));
    chk("t1_full_packet_cnt", 64'(packet_cnt), 64'(4));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_drain_valid", 64'(out_valid), 64'(1));
      chk("t1_drain_flit", 64'(out_flit), 64'(mk(T_S, 32'h100 + 32'(i))));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("t1_empty_valid", 64'(out_valid), 64'(0));
    chk("t1_empty_packet_cnt", 64'(packet_cnt), 64'(0));
    tick();

    // 2: occupancy 2, three simultaneous push+pop cycles
    for (int i = 0; i < 2; i++) begin
      in_flit  = mk(T_S, 32'h200 + 32'(i));
      in_valid = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      in_flit   = mk(T_S, 32'h202 + 32'(i));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("t2_pp_flit", 64'(out_flit), 64'(mk(T_S, 32'h200 + 32'(i))));
      chk("t2_pp_in_ready", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    chk("t2_packet_cnt", 64'(packet_cnt), 64'(2));
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_tail_valid", 64'(out_valid), 64'(1));
      chk("t2_tail_flit", 64'(out_flit), 64'(mk(T_S, 32'h203 + 32'(i))));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("t2_empty_valid", 64'(out_valid), 64'(0));
    tick();

    // 3: H,P,P,T packet counting
    for (int i = 0; i < 4; i++) begin
      in_flit  = mk(seq3[i], 32'h300 + 32'(i));
      in_valid = 1'b1;
      tick();
      chk("t3_push_packet_cnt", 64'(packet_cnt), (i == 3) ? 64'(1) : 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_pop_flit", 64'(out_flit), 64'(mk(seq3[i], 32'h300 + 32'(i))));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("t3_packet_cnt", 64'(packet_cnt), 64'(0));
    chk("t3_proto_err", 64'(proto_err), 64'(0));
    chk("t3_out_valid", 64'(out_valid), 64'(0));
    tick();

    // 4: stray PAYLOAD from IDLE sets a sticky error
    in_flit   = mk(T_P, 32'h400);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t4_proto_err_set", 64'(proto_err), 64'(1));
    for (int p = 0; p < 10; p++) begin
      if (p % 2 == 0) begin
        in_flit  = mk(T_S, 32'h410 + 32'(p));
        in_valid = 1'b1;
        tick();
      end else begin
        in_flit  = mk(T_H, 32'h420 + 32'(p));
        in_valid = 1'b1;
        tick();
        in_flit  = mk(T_P, 32'h430 + 32'(p));
        tick();
        in_flit  = mk(T_T, 32'h440 + 32'(p));
        tick();
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t4_proto_err_sticky", 64'(proto_err), 64'(1));
    chk("t4_drained", 64'(out_valid), 64'(0));
    chk("t4_packet_cnt", 64'(packet_cnt), 64'(0));
    out_ready = 1'b0;

    // 5: reset with three flits stored
    for (int i = 0; i < 3; i++) begin
      in_flit  = mk(T_S, 32'h500 + 32'(i));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t5_pre_packet_cnt", 64'(packet_cnt), 64'(3));
    chk("t5_pre_out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t5_rst_out_valid", 64'(out_valid), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("t5_post_out_valid", 64'(out_valid), 64'(0));
    chk("t5_post_packet_cnt", 64'(packet_cnt), 64'(0));
    chk("t5_post_in_ready", 64'(in_ready), 64'(1));
    chk("t5_post_proto_err", 64'(proto_err), 64'(0));
    tick();

    // 6: empty queue with the link ready
    in_flit   = mk(T_S, 32'h600);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
`ifdef LISNOC_OUTFIFO_BYPASS_EN
    chk("t6_bypass_valid", 64'(out_valid), 64'(1));
    chk("t6_bypass_flit", 64'(out_flit), 64'(mk(T_S, 32'h600)));
`else
    chk("t6_same_cycle_valid", 64'(out_valid), 64'(0));
`endif
    tick();
    in_valid = 1'b0;
    #1;
`ifdef LISNOC_OUTFIFO_BYPASS_EN
    chk("t6_after_valid", 64'(out_valid), 64'(0));
    chk("t6_after_packet_cnt", 64'(packet_cnt), 64'(0));
`else
    chk("t6_next_cycle_valid", 64'(out_valid), 64'(1));
    chk("t6_next_cycle_flit", 64'(out_flit), 64'(mk(T_S, 32'h600)));
`endif
    tick();
    chk("t6_final_valid", 64'(out_valid), 64'(0));
    chk("t6_final_packet_cnt", 64'(packet_cnt), 64'(0));
    out_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
